// File: rtl/gray_scan_pkg.sv
// Shared types and constants for the grayscale image scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gray_scan_pkg;

    localparam int PIX_W       = 24;
    localparam int CHAN_W      = 8;
    localparam int IMG_DIM_DEF = 64;
    localparam int COORD_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/gray_pix_conv.sv
// Converts one RGB pixel to gray = floor((max+min)/2), placed on the G channel.
// Latency: purely combinational.
// Backpressure: none (stateless).
module gray_pix_conv
    import gray_scan_pkg::*;
(
    input  logic [PIX_W-1:0] pix_i,
    output logic [PIX_W-1:0] pix_o
);

    logic [CHAN_W-1:0] ch_r;
    logic [CHAN_W-1:0] ch_g;
    logic [CHAN_W-1:0] ch_b;
    logic [CHAN_W-1:0] ch_max;
    logic [CHAN_W-1:0] ch_min;
    logic [CHAN_W:0]   ch_sum;

    assign ch_r = pix_i[23:16];
    assign ch_g = pix_i[15:8];
    assign ch_b = pix_i[7:0];

    // Channel extremes, summed one bit wider so 255+255 cannot overflow.
    always_comb begin
        ch_max = ch_r;
        if (ch_g > ch_max) ch_max = ch_g;
        if (ch_b > ch_max) ch_max = ch_b;
        ch_min = ch_r;
        if (ch_g < ch_min) ch_min = ch_g;
        if (ch_b < ch_min) ch_min = ch_b;
        ch_sum = {1'b0, ch_max} + {1'b0, ch_min};
        pix_o  = {8'h00, ch_sum[CHAN_W:1], 8'h00};
    end

endmodule

// File: rtl/gray_scan.sv
// Row-major grayscale pass over an IMG_DIM x IMG_DIM image, read then write per pixel.
// Latency: 2 cycles per pixel; gray_done rises 2*IMG_DIM*IMG_DIM edges after the start edge.
// Backpressure: optional hold input (GRAY_SCAN_HOLD_EN) freezes the scan in READ/WRITE.
module gray_scan
    import gray_scan_pkg::*;
#(
    parameter int IMG_DIM = IMG_DIM_DEF,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef GRAY_SCAN_HOLD_EN
    input  logic               hold,
`endif
    input  logic [PIX_W-1:0]   in_pix,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic               out_we,
    output logic [PIX_W-1:0]   out_pix,
    output logic               gray_done
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(IMG_DIM - 1);

    state_e             state_q,     state_d;
    logic [COORD_W-1:0] row_q,       row_d;
    logic [COORD_W-1:0] col_q,       col_d;
    logic [PIX_W-1:0]   out_pix_q,   out_pix_d;
    logic               out_we_q,    out_we_d;
    logic               gray_done_q, gray_done_d;
    logic [PIX_W-1:0]   conv_pix;
    logic               hold_w;

`ifdef GRAY_SCAN_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    gray_pix_conv u_conv (
        .pix_i (in_pix),
        .pix_o (conv_pix)
    );

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        out_pix_d   = out_pix_q;
        out_we_d    = 1'b0;
        gray_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            READ: begin
                if (!hold_w) begin
                    state_d   = WRITE;
                    out_pix_d = conv_pix;
                    out_we_d  = 1'b1;
                end
            end
            WRITE: begin
                if (hold_w) begin
                    // Write stays pending; the output gate below masks it meanwhile.
                    out_we_d = 1'b1;
                end else if (row_q == LAST && col_q == LAST) begin
                    state_d     = DONE;
                    gray_done_d = 1'b1;
                end else begin
                    state_d = READ;
                    if (col_q == LAST) begin
                        col_d = '0;
                        row_d = row_q + COORD_W'(1);
                    end else begin
                        col_d = col_q + COORD_W'(1);
                    end
                end
            end
            DONE: begin
                gray_done_d = 1'b1;
                if (start) begin
                    state_d     = READ;
                    row_d       = '0;
                    col_d       = '0;
                    gray_done_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            out_pix_q   <= '0;
            out_we_q    <= 1'b0;
            gray_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_pix_q   <= out_pix_d;
            out_we_q    <= out_we_d;
            gray_done_q <= gray_done_d;
        end
    end

    assign row       = row_q;
    assign col       = col_q;
    assign out_pix   = out_pix_q;
    assign out_we    = out_we_q & ~hold_w;
    assign gray_done = gray_done_q;

endmodule

// File: tb/tb_gray_scan.sv
// Randomized image passes checked against a behavioural scan/convert model.
// Latency: n/a (testbench).
// Backpressure: drives hold when GRAY_SCAN_HOLD_EN is defined.
module tb_gray_scan;

    localparam int IMG  = 64;
    localparam int CW   = 6;
    localparam int NPIX = IMG * IMG;

    logic          clk;
    logic          rst_n;
    logic          start;
`ifdef GRAY_SCAN_HOLD_EN
    logic          hold;
`endif
    logic [23:0]   in_pix;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          out_we;
    logic [23:0]   out_pix;
    logic          gray_done;

    logic [23:0]   mem [0:NPIX-1];
    logic [23:0]   dir_exp [0:3];

    int tests;
    int fails;

    gray_scan #(.IMG_DIM(IMG), .COORD_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef GRAY_SCAN_HOLD_EN
        .hold      (hold),
`endif
        .in_pix    (in_pix),
        .row       (row),
        .col       (col),
        .out_we    (out_we),
        .out_pix   (out_pix),
        .gray_done (gray_done)
    );

    // Input image memory, read combinationally at the DUT's current address.
    assign in_pix = mem[{row, col}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] ref_gray(input logic [23:0] p);
        int c [3];
        int mx;
        int mn;
        c[0] = int'(p[23:16]);
        c[1] = int'(p[15:8]);
        c[2] = int'(p[7:0]);
        mx = c[0];
        mn = c[0];
        for (int i = 1; i < 3; i++) begin
            if (c[i] > mx) mx = c[i];
            if (c[i] < mn) mn = c[i];
        end
        return {8'h00, 8'((mx + mn) / 2), 8'h00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_we"},   32'(out_we),    32'd0);
        chk({tag, "_done"}, 32'(gray_done), 32'd0);
    endtask

    // One pass from the start pulse. phase: 0 = read cycle, 1 = write cycle, 2 = done.
    // abort_k >= 0 asserts reset during that pixel's write; hold_k/hold_len stall a write.
    task automatic run_pass(input int abort_k, input int hold_k, input int hold_len, input bit first);
        int  k;
        int  edges;
        int  phase;
        int  hcnt;
        int  exp_done;
        bit  h;
        bit  done;
        exp_done = 2 * NPIX + hold_len;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        edges = 0;
        k     = 0;
        phase = 0;
        hcnt  = 0;
        h     = 1'b0;
        done  = 1'b0;
        for (int cyc = 0; cyc < exp_done + 16 && !done; cyc++) begin
            @(negedge clk);
            start = first && (k >= 60) && (k <= 66);
            h = (phase == 1) && (k == hold_k) && (hcnt < hold_len);
            if (h) hcnt++;
`ifdef GRAY_SCAN_HOLD_EN
            hold = h;
`endif
            #1;
            case (phase)
                0: begin
                    chk("rd_we",   32'(out_we),    32'd0);
                    chk("rd_done", 32'(gray_done), 32'd0);
                    chk("rd_row",  32'(row),       32'(k / IMG));
                    chk("rd_col",  32'(col),       32'(k % IMG));
                end
                1: begin
                    chk("wr_we",  32'(out_we),  h ? 32'd0 : 32'd1);
                    chk("wr_row", 32'(row),     32'(k / IMG));
                    chk("wr_col", 32'(col),     32'(k % IMG));
                    chk("wr_pix", 32'(out_pix), 32'(ref_gray(mem[k])));
                    if (first && k < 4) chk("dir_pix", 32'(out_pix), 32'(dir_exp[k]));
                    if (k == abort_k) begin
                        rst_n = 1'b0;
                        #1;
                        chk("rst_we",   32'(out_we),    32'd0);
                        chk("rst_done", 32'(gray_done), 32'd0);
                        chk("rst_row",  32'(row),       32'd0);
                        chk("rst_col",  32'(col),       32'd0);
                        chk("rst_pix",  32'(out_pix),   32'd0);
                        start = 1'b0;
                        return;
                    end
                end
                default: begin
                    chk("done_flag",  32'(gray_done), 32'd1);
                    chk("done_we",    32'(out_we),    32'd0);
                    chk("done_row",   32'(row),       32'(IMG - 1));
                    chk("done_col",   32'(col),       32'(IMG - 1));
                    chk("done_edges", 32'(edges),     32'(exp_done));
                    done = 1'b1;
                end
            endcase
            if (!done) begin
                @(posedge clk);
                edges++;
                if (!h) begin
                    if (phase == 0) begin
                        phase = 1;
                    end else begin
                        k++;
                        phase = (k == NPIX) ? 2 : 0;
                    end
                end
            end
        end
        start = 1'b0;
`ifdef GRAY_SCAN_HOLD_EN
        hold = 1'b0;
`endif
        chk("pass_complete", 32'(done), 32'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
`ifdef GRAY_SCAN_HOLD_EN
        hold  = 1'b0;
`endif
        for (int i = 0; i < NPIX; i++) mem[i] = 24'($urandom);
        mem[0] = 24'hFF0000;
        mem[1] = 24'h102030;
        mem[2] = 24'hFFFFFF;
        mem[3] = 24'h000000;
        dir_exp[0] = 24'h007F00;
        dir_exp[1] = 24'h002000;
        dir_exp[2] = 24'h00FF00;
        dir_exp[3] = 24'h000000;

        // Reset values while held in reset across clock edges.
        repeat (2) @(negedge clk);
        chk("reset_we",   32'(out_we),    32'd0);
        chk("reset_done", 32'(gray_done), 32'd0);
        chk("reset_row",  32'(row),       32'd0);
        chk("reset_col",  32'(col),       32'd0);
        chk("reset_pix",  32'(out_pix),   32'd0);

        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_idle("idle");
        end

        // Full pass with directed leading pixels and start pulsed across the row wrap.
        run_pass(-1, -1, 0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("hold_done_flag", 32'(gray_done), 32'd1);
            chk("hold_done_we",   32'(out_we),    32'd0);
        end

        // Fresh image, then a reset during the write of [10,5].
        for (int i = 0; i < NPIX; i++) mem[i] = 24'($urandom);
        run_pass(10 * IMG + 5, -1, 0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk_idle("in_reset");
            chk("in_reset_row", 32'(row), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_idle("post_reset");
        end
        run_pass(-1, -1, 0, 1'b0);

`ifdef GRAY_SCAN_HOLD_EN
        // Stall the write of [2,3] for five cycles.
        for (int i = 0; i < NPIX; i++) mem[i] = 24'($urandom);
        run_pass(-1, 2 * IMG + 3, 5, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gray_scan.md
GRAY_SCAN -- requirements
Module: gray_scan

Interface
REQ-001 SHALL have parameter IMG_DIM, default 64, image width and height in pixels (square image).
REQ-002 SHALL have parameter COORD_W, default 6, width of row/col coordinates (log2 IMG_DIM).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin a full-image grayscale pass.
REQ-006 SHALL have port in_pix  input  24  input-image pixel at [row,col], combinational read (R 23:16, G 15:8, B 7:0).
REQ-007 SHALL have port row  output  COORD_W  current pixel row, shared read and write address.
REQ-008 SHALL have port col  output  COORD_W  current pixel column, shared read and write address.
REQ-009 SHALL have port out_we  output  1  output-image write enable, one cycle per pixel.
REQ-010 SHALL have port out_pix  output  24  grayscale pixel written to [row,col] when out_we=1.
REQ-011 SHALL have port gray_done  output  1  high while the pass is complete.

Function
REQ-012 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-013 IDLE: start=1 -> READ with row=0, col=0; otherwise stay; out_we=0, gray_done=0.
REQ-014 READ (1 cycle): SHALL sample conversion of in_pix into out_pix register -> WRITE; out_we=0.
REQ-015 WRITE (1 cycle): out_we=1, row/col unchanged from READ, out_pix stable; then advance.
REQ-016 Advance SHALL be row-major: col+1; at col=IMG_DIM-1 col wraps to 0 and row+1; after WRITE of [IMG_DIM-1, IMG_DIM-1] -> DONE with row/col held at last pixel.
REQ-017 DONE: gray_done=1, out_we=0; start=1 -> READ with row=0, col=0 and gray_done low next cycle; otherwise stay.
REQ-018 start SHALL be ignored in READ and WRITE.
REQ-019 Throughput SHALL be exactly 2 cycles per pixel; DONE entered on the 2*IMG_DIM*IMG_DIM-th rising edge after the edge sampling start (8192 for default).
REQ-020 Conversion: max and min over the three 8-bit channels; sum in 9 bits (no overflow); gray = floor(sum/2), 8 bits.
REQ-021 out_pix SHALL be {8'h00, gray, 8'h00}: gray on G, R and B zero.
REQ-022 Exactly one out_we pulse per pixel per pass, never two writes to the same address in one pass.

Reset
REQ-023 rst_n=0 SHALL force, asynchronously: state=IDLE, row=0, col=0, out_pix=0, out_we=0, gray_done=0.
REQ-024 Reset mid-pass SHALL abort the pass with no further out_we; a new start after release restarts at [0,0].

Configuration
REQ-025 With GRAY_SCAN_HOLD_EN defined, SHALL add port hold (input, 1): hold=1 in READ or WRITE freezes state, row, col, out_pix and forces out_we=0; the pending write is issued after hold drops; hold ignored in IDLE and DONE.
REQ-026 Without GRAY_SCAN_HOLD_EN, port hold SHALL not exist and behaviour SHALL equal hold=0.

Structure
REQ-027 Package gray_scan_pkg SHALL hold the state enum type, PIX_W=24, CHAN_W=8, and default IMG_DIM/COORD_W constants.
REQ-028 Channel max/min/average SHALL live in one combinational sub-module gray_pix_conv (in 24 bits, out 24 bits), instantiated once.

Verification
REQ-029 in_pix=24'hFF0000 at [0,0] -> WRITE cycle out_we=1, out_pix=24'h007F00, row=0, col=0.
REQ-030 in_pix=24'h102030 -> out_pix=24'h002000; in_pix=24'hFFFFFF -> out_pix=24'h00FF00; in_pix=24'h000000 -> 24'h000000.
REQ-031 Full pass with memory model pix=f(row,col): exactly 4096 out_we pulses, addresses row-major [0,0]..[63,63], each value matches model; gray_done rises 8192 edges after start edge.
REQ-032 Wrap: at [0,63] WRITE next READ SHALL show row=1, col=0; start pulsed mid-pass -> no effect on sequence.
REQ-033 rst_n low during pixel [10,5] WRITE -> out_we, gray_done, row, col, out_pix immediately 0; restart completes full 4096-pixel pass.
REQ-034 With GRAY_SCAN_HOLD_EN: hold=1 for 5 cycles during WRITE of [2,3] -> out_we low for 5 cycles, then one write to [2,3]; gray_done delayed by exactly 5 cycles.
